branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 102 ++++++++++
 tb/tb_branch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - EX-stage branch resolution, fetch PC register and flush sequencer
module branch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [31:0] cmp_result,
  output logic [31:0] pc,
  output logic        flush,
  output logic        misalign,
  output logic [31:0] taken_count
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] pc_n, count_n;
  logic        flush_n, misalign_n;

  logic        taken;
  logic [31:0] base, sum, target, pc_plus4;
  logic        unused_cmp;

  // jalr wins the operand mux, so class priority jalr > jal > branch falls out here
  assign base       = ex_is_jalr ? ex_rs1 : ex_pc;
  assign sum        = base + ex_imm;
  assign target     = ex_is_jalr ? {sum[31:1], 1'b0} : sum;
  assign taken      = ex_valid & (ex_is_jalr | ex_is_jal | (ex_is_branch & cmp_result[0]));
  assign pc_plus4   = pc + 32'd4;
  assign unused_cmp = ^cmp_result[31:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      pc          <= RESET_PC;
      flush       <= 1'b0;
      misalign    <= 1'b0;
      taken_count <= 32'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pc          <= pc_n;
      flush       <= flush_n;
      misalign    <= misalign_n;
      taken_count <= count_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pc_n       = stall ? pc : pc_plus4;
    flush_n    = 1'b0;
    misalign_n = 1'b0;
    count_n    = taken_count;
    case (state)
      IDLE: begin
        if (taken) begin
          state_n = FLUSH;
          cnt_n   = FLUSH_INIT;
          flush_n = 1'b1;
          if (target[1]) begin
            pc_n       = TRAP_VEC;
            misalign_n = 1'b1;
          end else begin
            pc_n    = target;
            count_n = taken_count + 32'd1;
          end
        end
      end
      FLUSH: begin
        // wrong-path ex_* inputs are deliberately not looked at in this state
        if (cnt == 3'd0) begin
          state_n = IDLE;
          flush_n = 1'b0;
        end else begin
          cnt_n   = cnt - 3'd1;
          flush_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed self-checking bench for branch_unit
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1, cmp_result;
  logic        ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [31:0] pc, taken_count;
  logic        flush, misalign;

  int passed = 0;
  int total  = 0;

  branch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .cmp_result(cmp_result), .pc(pc), .flush(flush), .misalign(misalign),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_pc = 0; ex_imm = 0; ex_rs1 = 0; cmp_result = 0;
  endtask

  task automatic expect_state(string name, logic [31:0] epc, logic efl, logic emis, logic [31:0] ecnt);
    total++;
    if (pc !== epc || flush !== efl || misalign !== emis || taken_count !== ecnt)
      $display("FAIL %s: got pc=%h flush=%b misalign=%b count=%h, want pc=%h flush=%b misalign=%b count=%h",
               name, pc, flush, misalign, taken_count, epc, efl, emis, ecnt);
    else passed++;
  endtask

  task automatic test_reset();
    stall = 0; clear_ex();
    rst = 1;
    #1;
    expect_state("reset_async", 32'h0, 0, 0, 32'h0);
    edge_step();
    expect_state("reset_held", 32'h0, 0, 0, 32'h0);
    rst = 0;
  endtask

  task automatic test_sequential();
    edge_step(); expect_state("seq_4", 32'h4, 0, 0, 32'h0);
    edge_step(); expect_state("seq_8", 32'h8, 0, 0, 32'h0);
    edge_step(); expect_state("seq_c", 32'hC, 0, 0, 32'h0);
  endtask

  task automatic test_branch();
    ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h40; ex_imm = 32'h20; cmp_result = 32'h1;
    edge_step(); expect_state("br_taken", 32'h60, 1, 0, 32'h1);
    edge_step(); expect_state("br_flush2", 32'h64, 1, 0, 32'h1);
    clear_ex();
    edge_step(); expect_state("br_flush_end", 32'h68, 0, 0, 32'h1);
    ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h40; ex_imm = 32'h20; cmp_result = 32'hFFFF_FFFE;
    edge_step(); expect_state("br_not_taken", 32'h6C, 0, 0, 32'h1);
    clear_ex();
  endtask

  task automatic test_jalr_align();
    ex_valid = 1; ex_is_jalr = 1; ex_rs1 = 32'h1001; ex_imm = 32'h0;
    edge_step(); expect_state("jalr_bit0", 32'h1000, 1, 0, 32'h2);
    clear_ex();
    edge_step(); expect_state("jalr_flush2", 32'h1004, 1, 0, 32'h2);
    edge_step(); expect_state("jalr_idle", 32'h1008, 0, 0, 32'h2);
    ex_valid = 1; ex_is_jalr = 1; ex_rs1 = 32'h1002; ex_imm = 32'h0;
    edge_step(); expect_state("misalign_trap", 32'h100, 1, 1, 32'h2);
    clear_ex();
    edge_step(); expect_state("misalign_pulse_end", 32'h104, 1, 0, 32'h2);
    edge_step(); expect_state("misalign_idle", 32'h108, 0, 0, 32'h2);
  endtask

  task automatic test_priority();
    ex_valid = 1; ex_is_jalr = 1; ex_is_jal = 1; ex_is_branch = 1; cmp_result = 32'h1;
    ex_pc = 32'h500; ex_rs1 = 32'h3000; ex_imm = 32'h4;
    edge_step(); expect_state("prio_jalr", 32'h3004, 1, 0, 32'h3);
    clear_ex();
    edge_step();
    edge_step(); expect_state("prio_idle", 32'h300C, 0, 0, 32'h3);
  endtask

  task automatic test_stall_flush();
    stall = 1;
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h80; ex_imm = 32'h8;
    edge_step(); expect_state("stall_redirect", 32'h88, 1, 0, 32'h4);
    ex_pc = 32'h200; ex_imm = 32'h40;
    edge_step(); expect_state("flush_masks_jal", 32'h88, 1, 0, 32'h4);
    clear_ex();
    edge_step(); expect_state("stall_hold", 32'h88, 0, 0, 32'h4);
    stall = 0;
    edge_step(); expect_state("stall_release", 32'h8C, 0, 0, 32'h4);
  endtask

  task automatic test_wrap();
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h20;
    edge_step(); expect_state("target_wrap", 32'h10, 1, 0, 32'h5);
    clear_ex();
    edge_step();
    edge_step(); expect_state("wrap_idle", 32'h18, 0, 0, 32'h5);
    force dut.taken_count = 32'hFFFF_FFFF;
    #1;
    release dut.taken_count;
    #1;
    expect_state("count_preload", 32'h18, 0, 0, 32'hFFFF_FFFF);
    ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h40; ex_imm = 32'h20; cmp_result = 32'h1;
    edge_step(); expect_state("count_wrap", 32'h60, 1, 0, 32'h0);
    clear_ex();
    edge_step();
    edge_step(); expect_state("count_wrap_idle", 32'h68, 0, 0, 32'h0);
  endtask

  task automatic test_reset_mid_flush();
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h400; ex_imm = 32'h10;
    edge_step(); expect_state("pre_reset_redirect", 32'h410, 1, 0, 32'h1);
    #2;
    rst = 1;
    #1;
    expect_state("reset_mid_flush", 32'h0, 0, 0, 32'h0);
    edge_step(); expect_state("reset_ignores_inputs", 32'h0, 0, 0, 32'h0);
    clear_ex();
    rst = 0;
    edge_step(); expect_state("post_reset_idle", 32'h4, 0, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jalr_align();
    test_priority();
    test_stall_flush();
    test_wrap();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
